// File: rtl/sd_spi_host_if.sv
// Request/response and SPI pin bundle for the SD SPI host engine.
interface sd_spi_host_if;
  logic [7:0]  div;
  logic        cs_en;
  logic        byte_req;
  logic [7:0]  byte_tx;
  logic        cmd_req;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        busy;
  logic        done;
  logic [7:0]  rx_byte;
  logic        timeout;
  logic        sck;
  logic        mosi;
  logic        ss;
  logic        miso;

  modport master (
    output div, cs_en, byte_req, byte_tx, cmd_req, cmd_idx, cmd_arg, miso,
    input  busy, done, rx_byte, timeout, sck, mosi, ss
  );

  modport slave (
    input  div, cs_en, byte_req, byte_tx, cmd_req, cmd_idx, cmd_arg, miso,
    output busy, done, rx_byte, timeout, sck, mosi, ss
  );
endinterface

// File: rtl/sd_spi_host.sv
// SPI-mode SD host: raw full-duplex byte transfers and CRC7-framed commands
// with R1 polling, clocked entirely from clk_sys.
module sd_spi_host #(
  parameter int unsigned R1_POLL = 8
) (
  input  logic clk_sys,
  input  logic reset,
  sd_spi_host_if.slave bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ARG_W  = 32;
  localparam int unsigned CRC_W  = 7;
  localparam int unsigned CNT_W  = 3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RAW      = 3'd1;
  localparam logic [2:0] S_CMD_SEND = 3'd2;
  localparam logic [2:0] S_CMD_POLL = 3'd3;
  localparam logic [2:0] S_FINISH   = 3'd4;

  localparam logic [CNT_W-1:0]  LAST_BIT      = CNT_W'(7);
  localparam logic [CNT_W-1:0]  CRC_BYTE      = CNT_W'(5);
  localparam logic [CNT_W-1:0]  LAST_ARG_BYTE = CNT_W'(4);
  localparam logic [BYTE_W-1:0] POLL_LAST     = BYTE_W'(R1_POLL - 1);

  logic [2:0]        state_q, state_d;
  logic [BYTE_W-1:0] hcnt_q, hcnt_d;
  logic [BYTE_W-1:0] div_q, div_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0]  byte_q, byte_d;
  logic [BYTE_W-1:0] poll_q, poll_d;
  logic [BYTE_W-2:0] tx_sh_q, tx_sh_d;
  logic [BYTE_W-1:0] rx_sh_q, rx_sh_d;
  logic [ARG_W-1:0]  arg_q, arg_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
  logic sck_q, sck_d, mosi_q, mosi_d, ss_q, ss_d;
  logic busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic cmd_act_q, cmd_act_d;

  logic              byte_end;
  logic              load_en;
  logic [BYTE_W-1:0] load_byte;

  // Serial CRC7 step, polynomial x^7 + x^3 + 1.
  function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    crc7_step = {c[CRC_W-2:0], fb} ^ {3'b000, fb, 3'b000};
  endfunction

  assign bus.sck     = sck_q;
  assign bus.mosi    = mosi_q;
  assign bus.ss      = ss_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_byte = rx_byte_q;
  assign bus.timeout = timeout_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      poll_q    <= '0;
      tx_sh_q   <= '1;
      rx_sh_q   <= '1;
      arg_q     <= '0;
      crc_q     <= '0;
      rx_byte_q <= '1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b1;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cmd_act_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      poll_q    <= poll_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      arg_q     <= arg_d;
      crc_q     <= crc_d;
      rx_byte_q <= rx_byte_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cmd_act_q <= cmd_act_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    poll_d    = poll_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    arg_d     = arg_q;
    crc_d     = crc_q;
    rx_byte_d = rx_byte_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    cmd_act_d = cmd_act_q;
    byte_end  = 1'b0;
    load_en   = 1'b0;
    load_byte = '1;

    // Byte engine: sample miso on the rising sck edge, advance mosi on the falling one.
    if (state_q == S_RAW || state_q == S_CMD_SEND || state_q == S_CMD_POLL) begin
      if (hcnt_q == div_q) begin
        hcnt_d = '0;
        if (!sck_q) begin
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh_q[BYTE_W-2:0], bus.miso};
          if (state_q == S_CMD_SEND && byte_q != CRC_BYTE) begin
            crc_d = crc7_step(crc_q, mosi_q);
          end
        end else begin
          sck_d = 1'b0;
          if (bit_q == LAST_BIT) begin
            byte_end = 1'b1;
          end else begin
            bit_d   = bit_q + CNT_W'(1);
            mosi_d  = tx_sh_q[BYTE_W-2];
            tx_sh_d = {tx_sh_q[BYTE_W-3:0], 1'b1};
          end
        end
      end else begin
        hcnt_d = hcnt_q + BYTE_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_req) begin
          state_d   = S_CMD_SEND;
          busy_d    = 1'b1;
          cmd_act_d = 1'b1;
          timeout_d = 1'b0;
          byte_d    = '0;
          crc_d     = '0;
          arg_d     = bus.cmd_arg;
          load_en   = 1'b1;
          load_byte = {2'b01, bus.cmd_idx};
        end else if (bus.byte_req) begin
          state_d   = S_RAW;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          load_en   = 1'b1;
          load_byte = bus.byte_tx;
        end
      end
      S_RAW: begin
        if (byte_end) begin
          rx_byte_d = rx_sh_q;
          state_d   = S_FINISH;
        end
      end
      S_CMD_SEND: begin
        // Bytes follow each other with no gap; the CRC byte closes the frame.
        if (byte_end) begin
          load_en = 1'b1;
          if (byte_q == CRC_BYTE) begin
            state_d = S_CMD_POLL;
            poll_d  = '0;
          end else begin
            byte_d    = byte_q + CNT_W'(1);
            arg_d     = {arg_q[ARG_W-BYTE_W-1:0], BYTE_W'(0)};
            load_byte = (byte_q == LAST_ARG_BYTE) ? {crc_q, 1'b1} : arg_q[ARG_W-1 -: BYTE_W];
          end
        end
      end
      S_CMD_POLL: begin
        if (byte_end) begin
          if (!rx_sh_q[BYTE_W-1]) begin
            rx_byte_d = rx_sh_q;
            state_d   = S_FINISH;
          end else if (poll_q == POLL_LAST) begin
            rx_byte_d = '1;
            timeout_d = 1'b1;
            state_d   = S_FINISH;
          end else begin
            poll_d  = poll_q + BYTE_W'(1);
            load_en = 1'b1;
          end
        end
      end
      S_FINISH: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        cmd_act_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_en) begin
      div_d   = bus.div;
      hcnt_d  = '0;
      bit_d   = '0;
      sck_d   = 1'b0;
      tx_sh_d = load_byte[BYTE_W-2:0];
      mosi_d  = load_byte[BYTE_W-1];
    end
    if (state_d == S_FINISH) begin
      mosi_d = 1'b1;
    end
    ss_d = ~(bus.cs_en | cmd_act_d);
  end

endmodule
